// File: rtl/lq_entry_push_arbiter_if.sv
// Requester-side and FIFO-side signals of the LQ entry push arbiter.
// The slave modport is the arbiter. The master modport is the requesters together with the FIFO.
interface lq_entry_push_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          fifo_push;
  logic                          fifo_potential_push;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_pop;
  logic [CNT_W-1:0]              occupancy;
  logic                          full;

  modport master (
    output req_valid, req_lock, req_data, fifo_pop,
    input  req_ack, fifo_push, fifo_potential_push, fifo_data_in, occupancy, full
  );

  modport slave (
    input  req_valid, req_lock, req_data, fifo_pop,
    output req_ack, fifo_push, fifo_potential_push, fifo_data_in, occupancy, full
  );
endinterface

// File: rtl/lq_entry_push_arbiter.sv
// Credit-gated round-robin arbiter for the LQ FIFO push port, with locked bursts.
// Meaning of each state: ST_OPEN arbitrates round-robin among all valid requesters. ST_LOCKED grants only owner_q until its final beat.
module lq_entry_push_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  lq_entry_push_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   credits_q, credits_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] elig_dbl;
  logic [NUM_REQ-1:0]   elig_rot;
  logic [PTR_W:0]       cand_sum;
  logic                 cand_found;
  logic [PTR_W-1:0]     cand_idx;
  logic [PTR_W-1:0]     cand_next;
  logic                 can_push;
  logic                 push;

  // Rotate eligibility so that rr_ptr lands at bit 0. The lowest set bit is then the candidate.
  always_comb begin
    eligible = bus.req_valid;
    if (state_q == ST_LOCKED) eligible = bus.req_valid & (NUM_REQ'(1) << owner_q);
    elig_dbl   = {eligible, eligible};
    elig_rot   = elig_dbl[rr_ptr_q +: NUM_REQ];
    cand_found = 1'b0;
    cand_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        cand_found = 1'b1;
        cand_sum   = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      end
    end
    if (cand_sum >= (PTR_W+1)'(NUM_REQ)) cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
    cand_idx  = cand_sum[PTR_W-1:0];
    cand_next = (cand_idx == PTR_W'(NUM_REQ - 1)) ? '0 : cand_idx + PTR_W'(1);
  end

  always_comb begin
    can_push                = (credits_q != '0) | bus.fifo_pop;
    push                    = cand_found & can_push;
    bus.fifo_push           = push;
    bus.fifo_potential_push = |bus.req_valid;
    bus.fifo_data_in        = bus.req_data[int'(cand_idx)*DATA_WIDTH +: DATA_WIDTH];
    bus.req_ack             = push ? (NUM_REQ'(1) << cand_idx) : '0;
    bus.occupancy           = CNT_W'(FIFO_DEPTH) - credits_q;
    bus.full                = (credits_q == '0);
    credits_d               = credits_q - CNT_W'(push) + CNT_W'(bus.fifo_pop);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    unique case (state_q)
      ST_OPEN: begin
        if (push) begin
          if (bus.req_lock[cand_idx]) begin
            state_d = ST_LOCKED;
            owner_d = cand_idx;
          end else begin
            rr_ptr_d = cand_next;
          end
        end
      end
      ST_LOCKED: begin
        // Only the owner can be the candidate here.
        if (push && !bus.req_lock[owner_q]) begin
          state_d  = ST_OPEN;
          rr_ptr_d = cand_next;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      credits_q <= CNT_W'(FIFO_DEPTH);
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ack));
  a_push_credit: assert property (@(posedge clk) disable iff (rst)
    bus.fifo_push |-> (credits_q != '0 || bus.fifo_pop));
  a_credit_max: assert property (@(posedge clk) disable iff (rst) credits_q <= CNT_W'(FIFO_DEPTH));
  a_pop_empty: assert property (@(posedge clk) disable iff (rst)
    (bus.fifo_pop && credits_q == CNT_W'(FIFO_DEPTH)) |-> push);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_proto
    // A valid requester that has not been acked must keep req_valid asserted.
    a_hold_valid: assert property (@(posedge clk)
      (!rst && bus.req_valid[i] && !bus.req_ack[i]) |=> (rst || bus.req_valid[i]));
  end
endmodule

// File: tb/tb_lq_entry_push_arbiter.sv
// Directed-vector bench for lq_entry_push_arbiter (NUM_REQ=3, FIFO_DEPTH=4).
module tb_lq_entry_push_arbiter;
  localparam int NR = 3;
  localparam int FD = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lq_entry_push_arbiter_if #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .DATA_WIDTH(DW)) bus ();

  lq_entry_push_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r;
    logic [2:0] v;
    logic [2:0] l;
    logic       p;
    logic [2:0] ack;
    logic       push;
    int         cand;
    int         occ;
    logic       full;
  } vec_t;

  logic [DW-1:0] dat [NR];
  vec_t          tbl [$];

  function automatic vec_t mk(logic r, logic [2:0] v, logic [2:0] l, logic p,
                              logic [2:0] ack, logic push, int cand, int occ, logic full);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.p = p;
    t.ack = ack; t.push = push; t.cand = cand; t.occ = occ; t.full = full;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    rst               = t.r;
    bus.req_valid     = t.v;
    bus.req_lock      = t.l;
    bus.fifo_pop      = t.p;
    #1;
    if (!t.r) begin
      chk({tag, " ack"}, 64'(bus.req_ack), 64'(t.ack));
      chk({tag, " push"}, 64'(bus.fifo_push), 64'(t.push));
      chk({tag, " potential_push"}, 64'(bus.fifo_potential_push), 64'(|t.v));
      if (t.cand >= 0) chk({tag, " data_in"}, 64'(bus.fifo_data_in), 64'(dat[t.cand]));
    end
    @(posedge clk);
    #1;
    chk({tag, " occupancy"}, 64'(bus.occupancy), 64'(t.occ));
    chk({tag, " full"}, 64'(bus.full), 64'(t.full));
  endtask

  initial begin
    rst           = 1'b1;
    dat[0]        = 32'h1111_0000;
    dat[1]        = 32'h2222_0001;
    dat[2]        = 32'h3333_0002;
    bus.req_data  = {dat[2], dat[1], dat[0]};
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.fifo_pop  = 1'b0;
    @(posedge clk);
    #1;

    // fairness: round-robin fill, full stall, pops release next in order
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 3'b001, 1,  0, 1, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 3'b010, 1,  1, 2, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 3'b100, 1,  2, 3, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 3'b001, 1,  0, 4, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 3'b000, 0,  1, 4, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 3'b010, 1,  1, 4, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 3'b100, 1,  2, 4, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0));
    // full with pop, then potential push without credit
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 1, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 2, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 3, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 4, 1));
    tbl.push_back(mk(0, 3'b010, 3'b000, 1, 3'b010, 1,  1, 4, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b000, 0,  0, 4, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0));
    // credit return, push+pop at full credits, rr_ptr wrap
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 1, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 2, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 3, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 4, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 0, -1, 3, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 0, -1, 2, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 0, -1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 0, -1, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 1, 3'b010, 1,  1, 0, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 0, 3'b100, 1,  2, 1, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 3'b001, 1,  0, 2, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 3'b010, 1,  1, 3, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 4, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // locked burst by req1 with a gap beat, then grant moves to req2
    run_vec(mk(0, 3'b001, 3'b000, 0, 3'b001, 1,  0, 1, 0), "lock_pre");
    run_vec(mk(0, 3'b111, 3'b010, 1, 3'b010, 1,  1, 1, 0), "lock_beat1");
    run_vec(mk(0, 3'b111, 3'b010, 0, 3'b010, 1,  1, 2, 0), "lock_beat2");
    run_vec(mk(0, 3'b101, 3'b010, 0, 3'b000, 0, -1, 2, 0), "lock_gap");
    run_vec(mk(0, 3'b111, 3'b000, 0, 3'b010, 1,  1, 3, 0), "lock_beat3");
    run_vec(mk(0, 3'b101, 3'b000, 0, 3'b100, 1,  2, 4, 1), "lock_after");
    run_vec(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0), "lock_rst");

    // reset in the middle of a burst owned by req2
    run_vec(mk(0, 3'b100, 3'b100, 0, 3'b100, 1,  2, 1, 0), "mid_beat1");
    run_vec(mk(0, 3'b101, 3'b100, 0, 3'b100, 1,  2, 2, 0), "mid_beat2");
    run_vec(mk(1, 3'b101, 3'b100, 0, 3'b000, 0, -1, 0, 0), "mid_rst");
    run_vec(mk(0, 3'b101, 3'b000, 0, 3'b001, 1,  0, 1, 0), "mid_after");
    run_vec(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, -1, 0, 0), "end_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
